// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch mode/time-keeping core.
// Holds state encoding, BCD digit width and default wrap limits.
package stopwatch_pkg;

    localparam int DIGIT_W     = 4;
    localparam int DEF_MAX_MIN = 59;
    localparam int DEF_MAX_SEC = 59;

    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        RUN    = 2'd1,
        ADJUST = 2'd2
    } state_t;

    function automatic logic [2*DIGIT_W-1:0] to_bcd(input int v);
        to_bcd = {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd.sv
// Registered two-digit BCD counter wrapping at a programmable BCD value.
// carry_out is combinational so the next field can step on the same edge.
module bcd_mod_counter
    import stopwatch_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_inc,
    input  logic [2*DIGIT_W-1:0] i_wrap,
    output logic [DIGIT_W-1:0]   o_tens,
    output logic [DIGIT_W-1:0]   o_ones,
    output logic                 o_carry
);

    logic [DIGIT_W-1:0] r_tens;
    logic [DIGIT_W-1:0] r_ones;
    logic               w_at_wrap;

    assign w_at_wrap = ({r_tens, r_ones} == i_wrap);
    assign o_carry   = i_inc & w_at_wrap;
    assign o_tens    = r_tens;
    assign o_ones    = r_ones;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tens <= '0;
            r_ones <= '0;
        end else if (i_inc) begin
            if (w_at_wrap) begin
                r_tens <= '0;
                r_ones <= '0;
            end else if (r_ones == 4'd9) begin
                r_ones <= '0;
                r_tens <= r_tens + 4'd1;
            end else begin
                r_ones <= r_ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode FSM (PAUSED/RUN/ADJUST), MM:SS BCD time and flash blanking.
// Every output is a register updated from the next-state view of this cycle.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int MAX_MIN = DEF_MAX_MIN,
    parameter int MAX_SEC = DEF_MAX_SEC
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               tick_1hz,
    input  logic               tick_2hz,
    input  logic               pause_pulse,
    input  logic               adj,
    input  logic               sel,
    output logic               div_en,
    output logic               running,
    output logic [DIGIT_W-1:0] min_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic               blank_min,
    output logic               blank_sec
);

    localparam logic [2*DIGIT_W-1:0] MIN_WRAP = to_bcd(MAX_MIN);
    localparam logic [2*DIGIT_W-1:0] SEC_WRAP = to_bcd(MAX_SEC);

    state_t r_state;
    state_t w_state_n;
    logic   r_resume;
    logic   w_resume_n;
    logic   r_flash;
    logic   w_flash_n;
    logic   r_running;
    logic   r_div_en;
    logic   r_blank_min;
    logic   r_blank_sec;
    logic   w_sec_inc;
    logic   w_min_inc;
    logic   w_sec_carry;
    logic   w_min_carry;
    logic   w_adj_tick;

    assign w_adj_tick = (r_state == ADJUST) & tick_2hz;
    assign w_sec_inc  = ((r_state == RUN) & tick_1hz) | (w_adj_tick & sel);
    // Carry only chains fields while running; adjust steps fields independently.
    assign w_min_inc  = ((r_state == RUN) & w_sec_carry) | (w_adj_tick & ~sel);

    bcd_mod_counter u_sec (
        .i_clk   (clk_in),
        .i_rst   (rst),
        .i_inc   (w_sec_inc),
        .i_wrap  (SEC_WRAP),
        .o_tens  (sec_tens),
        .o_ones  (sec_ones),
        .o_carry (w_sec_carry)
    );

    bcd_mod_counter u_min (
        .i_clk   (clk_in),
        .i_rst   (rst),
        .i_inc   (w_min_inc),
        .i_wrap  (MIN_WRAP),
        .o_tens  (min_tens),
        .o_ones  (min_ones),
        .o_carry (w_min_carry)
    );

    always_comb begin
        w_state_n  = r_state;
        w_resume_n = r_resume;
        w_flash_n  = r_flash;
        unique case (r_state)
            PAUSED: begin
                if (adj) begin
                    w_state_n  = ADJUST;
                    w_resume_n = 1'b0;
                end else if (pause_pulse) begin
                    w_state_n = RUN;
                end
            end
            RUN: begin
                if (adj) begin
                    w_state_n  = ADJUST;
                    w_resume_n = 1'b1;
                end else if (pause_pulse) begin
                    w_state_n = PAUSED;
                end
            end
            ADJUST: begin
                if (!adj) begin
                    w_state_n = r_resume ? RUN : PAUSED;
                end
            end
            default: w_state_n = PAUSED;
        endcase
        if (w_state_n != ADJUST) begin
            w_flash_n = 1'b0;
        end else if (w_adj_tick) begin
            w_flash_n = ~r_flash;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state     <= PAUSED;
            r_resume    <= 1'b0;
            r_flash     <= 1'b0;
            r_running   <= 1'b0;
            r_div_en    <= 1'b0;
            r_blank_min <= 1'b0;
            r_blank_sec <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_resume    <= w_resume_n;
            r_flash     <= w_flash_n;
            r_running   <= (w_state_n == RUN);
            r_div_en    <= (w_state_n == RUN);
            r_blank_min <= w_flash_n & ~sel;
            r_blank_sec <= w_flash_n & sel;
        end
    end

    assign running   = r_running;
    assign div_en    = r_div_en;
    assign blank_min = r_blank_min;
    assign blank_sec = r_blank_sec;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboarded bench for stopwatch_ctrl: a behavioural MM:SS/state model
// pushes the expected output word per cycle; it is popped after the edge.
module tb_stopwatch_ctrl;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       tick_2hz = 1'b0;
    logic       pause_pulse = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic       div_en;
    logic       running;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       blank_min;
    logic       blank_sec;

    int n_total = 0;
    int n_bad = 0;

    logic [19:0] sb_q[$];

    int m_min = 0;
    int m_sec = 0;
    int m_st = 0;
    bit m_res = 0;
    bit m_flash = 0;

    stopwatch_ctrl dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .tick_1hz    (tick_1hz),
        .tick_2hz    (tick_2hz),
        .pause_pulse (pause_pulse),
        .adj         (adj),
        .sel         (sel),
        .div_en      (div_en),
        .running     (running),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .blank_min   (blank_min),
        .blank_sec   (blank_sec)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [19:0] obs_word();
        return {running, div_en, blank_min, blank_sec,
                min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    function automatic logic [19:0] mk(bit run, bit bm, bit bs, int mm, int ss);
        return {run, run, bm, bs, 4'(mm / 10), 4'(mm % 10),
                4'(ss / 10), 4'(ss % 10)};
    endfunction

    task chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // model: 0=PAUSED 1=RUN 2=ADJUST
    task model();
        int ns;
        if (rst) begin
            m_min = 0; m_sec = 0; m_st = 0; m_res = 0; m_flash = 0;
        end else begin
            if (m_st == 1 && tick_1hz) begin
                m_sec++;
                if (m_sec > 59) begin
                    m_sec = 0;
                    m_min = (m_min + 1) % 60;
                end
            end
            if (m_st == 2 && tick_2hz) begin
                if (sel) m_sec = (m_sec + 1) % 60;
                else     m_min = (m_min + 1) % 60;
            end
            ns = m_st;
            if (m_st == 0) begin
                if (adj) begin ns = 2; m_res = 0; end
                else if (pause_pulse) ns = 1;
            end else if (m_st == 1) begin
                if (adj) begin ns = 2; m_res = 1; end
                else if (pause_pulse) ns = 0;
            end else if (!adj) begin
                ns = m_res ? 1 : 0;
            end
            if (ns != 2) m_flash = 0;
            else if (m_st == 2 && tick_2hz) m_flash = ~m_flash;
            m_st = ns;
        end
        sb_q.push_back(mk(m_st == 1, m_flash & ~sel, m_flash & sel,
                          m_min, m_sec));
    endtask

    task step(input string tag, input bit r, input bit t1,
              input bit t2, input bit pp);
        rst = r;
        tick_1hz = t1;
        tick_2hz = t2;
        pause_pulse = pp;
        model();
        @(posedge clk_in);
        #1;
        if (sb_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            chk(tag, obs_word(), sb_q.pop_front());
        end
        rst = 0; tick_1hz = 0; tick_2hz = 0; pause_pulse = 0;
    endtask

    initial begin
        step("rst0", 1, 0, 0, 0);
        step("rst1", 1, 1, 1, 1);
        chk("t1_rst_init", obs_word(), mk(0, 0, 0, 0, 0));

        // set 12:34 through adjust, then run
        adj = 1; sel = 0;
        step("t1_enter", 0, 0, 0, 0);
        repeat (12) step("t1_min", 0, 0, 1, 0);
        sel = 1;
        repeat (34) step("t1_sec", 0, 0, 1, 0);
        adj = 0;
        step("t1_exit", 0, 0, 0, 0);
        chk("t1_paused_1234", obs_word(), mk(0, 0, 0, 12, 34));
        step("t1_go", 0, 0, 0, 1);
        step("t1_rsta", 1, 1, 0, 1);
        step("t1_rstb", 1, 0, 1, 0);
        step("t1_rstc", 1, 1, 0, 0);
        chk("t1_rst_mid", obs_word(), mk(0, 0, 0, 0, 0));

        step("t2_go", 0, 0, 0, 1);
        repeat (61) begin
            step("t2_tick", 0, 1, 0, 0);
            step("t2_idle", 0, 0, 0, 0);
        end
        chk("t2_0101", obs_word(), mk(1, 0, 0, 1, 1));

        adj = 1; sel = 0;
        step("t3_enter", 0, 0, 0, 0);
        repeat (58) step("t3_min", 0, 0, 1, 0);
        sel = 1;
        repeat (58) step("t3_sec", 0, 0, 1, 0);
        adj = 0;
        step("t3_exit", 0, 0, 0, 0);
        chk("t3_5959", obs_word(), mk(1, 0, 0, 59, 59));
        step("t3_wrap", 0, 1, 0, 0);
        chk("t3_0000", obs_word(), mk(1, 0, 0, 0, 0));

        repeat (10) step("t4_tick", 0, 1, 0, 0);
        step("t4_both", 0, 1, 0, 1);
        chk("t4_0011_paused", obs_word(), mk(0, 0, 0, 0, 11));
        repeat (3) step("t4_ign", 0, 1, 0, 0);
        chk("t4_hold", obs_word(), mk(0, 0, 0, 0, 11));

        step("t5_go", 0, 0, 0, 1);
        repeat (47) step("t5_tick", 0, 1, 0, 0);
        chk("t5_0058", obs_word(), mk(1, 0, 0, 0, 58));
        adj = 1; sel = 1;
        step("t5_enter", 0, 0, 0, 0);
        step("t5_f1", 0, 0, 1, 0);
        chk("t5_blank1", obs_word(), mk(0, 0, 1, 0, 59));
        step("t5_f2", 0, 0, 1, 0);
        chk("t5_blank0", obs_word(), mk(0, 0, 0, 0, 0));
        step("t5_f3", 0, 0, 1, 0);
        chk("t5_blank1b", obs_word(), mk(0, 0, 1, 0, 1));
        sel = 0;
        step("t5_selmove", 0, 0, 0, 0);
        chk("t5_blank_moved", obs_word(), mk(0, 1, 0, 0, 1));
        sel = 1;
        step("t5_t1t2", 0, 1, 1, 0);
        step("t5_t1only", 0, 1, 0, 1);
        adj = 0;
        step("t5_exit", 0, 0, 0, 0);
        chk("t5_run", obs_word(), mk(1, 0, 0, 0, 2));

        step("t6_stop", 0, 0, 0, 1);
        adj = 1; sel = 0;
        step("t6_enter", 0, 0, 0, 0);
        step("t6_pp1", 0, 0, 0, 1);
        step("t6_t2a", 0, 0, 1, 0);
        step("t6_pp2", 0, 0, 0, 1);
        step("t6_t2b", 0, 0, 1, 0);
        adj = 0;
        step("t6_exit", 0, 0, 0, 0);
        chk("t6_paused", obs_word(), mk(0, 0, 0, 2, 2));
        step("t6_idle", 0, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
